// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined bitwise logic unit with valid/ready handshakes
//
// Purpose:
//   Computes XOR / OR / AND / PASS_A (plus XNOR / ORN / ANDN when the
//   LOGIC_ZBB_EN macro is defined) on the accept edge and carries the result
//   through a STAGES-deep register pipeline. Both sides use valid/ready
//   handshakes; a stalled output freezes the pipe without bubbles.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 1)
//   STAGES  pipeline register stages, legal 1..4
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of every in-flight op
//   in_valid   upstream op valid
//   in_ready   unit accepts an op this cycle (combinational from out_ready)
//   op         3-bit operation code
//   a, b       operands
//   out_valid  result valid (last stage)
//   out_ready  downstream accepts result
//   Y          result
//   err        result came from an illegal op (qualified by out_valid)
//   busy       any stage holds a valid op
//
// Configuration macro:
//   LOGIC_ZBB_EN  when defined, ops 100/101/110 are XNOR/ORN/ANDN; otherwise
//                 they are illegal (Y=0, err=1). Op 111 is always illegal.

module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             err,
  output logic             busy
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("logic_unit_pipe: STAGES must be in 1..4");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("logic_unit_pipe: WIDTH must be >= 1");
    end
  endgenerate

  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
`ifdef LOGIC_ZBB_EN
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
`endif

  // Per-stage state: valid flag, result data and error flag.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] e;
  logic [WIDTH-1:0]  d [STAGES];

  logic [WIDTH-1:0]  res;
  logic              res_err;
  logic              accept;

  // Operation decode; everything not explicitly listed is illegal.
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op)
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_PASS: res = a;
`ifdef LOGIC_ZBB_EN
      OP_XNOR: res = ~(a ^ b);
      OP_ORN:  res = a | ~b;
      OP_ANDN: res = a & ~b;
`endif
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  // Advance chain, resolved from the output back to stage 0. A stage moves
  // its op on when its successor is empty or is itself moving, so a full
  // pipe with out_ready=1 streams one op per cycle with no bubbles. The
  // running term lives in a local so adv never reads its own bits.
  always_comb begin
    logic nxt;
    adv         = '0;
    nxt         = v[STAGES-1] & out_ready;
    adv[STAGES-1] = nxt;
    for (int i = STAGES - 2; i >= 0; i--) begin
      nxt    = v[i] & (~v[i+1] | nxt);
      adv[i] = nxt;
    end
  end

  // No skid buffer: readiness ripples straight back from out_ready.
  assign in_ready = ~flush & (~v[0] | adv[0]);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
      end
    end else begin
      // Stage 0: flush wins over a new accept (accept is already masked by
      // flush through in_ready, the explicit order keeps intent obvious).
      if (flush) begin
        v[0] <= 1'b0;
      end else if (accept) begin
        v[0] <= 1'b1;
      end else if (adv[0]) begin
        v[0] <= 1'b0;
      end
      if (accept) begin
        d[0] <= res;
        e[0] <= res_err;
      end

      // Later stages only move data; empty stages keep stale data.
      for (int i = 1; i < STAGES; i++) begin
        if (flush) begin
          v[i] <= 1'b0;
        end else if (adv[i-1]) begin
          v[i] <= 1'b1;
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
        if (adv[i-1]) begin
          d[i] <= d[i-1];
          e[i] <= e[i-1];
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign Y         = d[STAGES-1];
  assign err       = e[STAGES-1];
  assign busy      = |v;

  // A stalled result must stay put until taken (or flushed away).
  a_stall_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(Y) && $stable(err))
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe at STAGES 2, 1 and 4
module tb_logic_unit_pipe;

  localparam int W    = 32;
  localparam int NI   = 3;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic           flush     [NI];
  logic           in_valid  [NI];
  logic           in_ready  [NI];
  logic [2:0]     op        [NI];
  logic [W-1:0]   a         [NI];
  logic [W-1:0]   b         [NI];
  logic           out_valid [NI];
  logic           out_ready [NI];
  logic [W-1:0]   y         [NI];
  logic           err       [NI];
  logic           busy      [NI];

  // Instance 0: STAGES=2, instance 1: STAGES=1, instance 2: STAGES=4.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic_unit_pipe #(
      .WIDTH (W),
      .STAGES((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .op       (op[g]),
      .a        (a[g]),
      .b        (b[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .Y        (y[g]),
      .err      (err[g]),
      .busy     (busy[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture: every output handshake is recorded with its cycle.
  logic [W-1:0] got_y   [NI][64];
  logic         got_e   [NI][64];
  int           got_cyc [NI][64];
  int           got_n   [NI] = '{default: 0};

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_n && out_valid[k] && out_ready[k]) begin
        got_y[k][got_n[k] % 64]   <= y[k];
        got_e[k][got_n[k] % 64]   <= err[k];
        got_cyc[k][got_n[k] % 64] <= cyc;
        got_n[k]                  <= got_n[k] + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] exp_q [$];
  int         acc_q [$];

  function automatic int stages_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  // Reference behaviour: {err, result}.
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] z);
    case (o)
      3'd0: return {1'b0, x ^ z};
      3'd1: return {1'b0, x | z};
      3'd2: return {1'b0, x & z};
      3'd3: return {1'b0, x};
`ifdef LOGIC_ZBB_EN
      3'd4: return {1'b0, x ~^ z};
      3'd5: return {1'b0, x | ~z};
      3'd6: return {1'b0, x & ~z};
`endif
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset out_valid[%0d]: got %b expected 0", k, out_valid[k]);
      end
      n_checks++;
      if (y[k] !== '0) begin
        n_errors++;
        $display("FAIL reset Y[%0d]: got %h expected 0", k, y[k]);
      end
      n_checks++;
      if (err[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset err[%0d]: got %b expected 0", k, err[k]);
      end
      n_checks++;
      if (busy[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset busy[%0d]: got %b expected 0", k, busy[k]);
      end
      n_checks++;
      if (in_ready[k] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset in_ready[%0d]: got %b expected 1", k, in_ready[k]);
      end
    end
    tick();
  endtask

  task automatic test_stream(input int k);
    logic [W-1:0] av [4];
    logic [W-1:0] bv [4];
    logic [W-1:0] want [4];
    logic [W:0]   ex;
    int s, base, rd, ac;
    av   = '{32'h00000000, 32'h00000000, 32'h12345678, 32'hDEADBEEF};
    bv   = '{32'h00000000, 32'hFFFFFFFF, 32'h00FF00FF, 32'h0F0F0F0F};
    want = '{32'h00000000, 32'hFFFFFFFF, 32'h12CB5687, 32'hD1A2B1E0};
    s = stages_of(k);
    exp_q.delete();
    acc_q.delete();
    base = got_n[k];
    rd   = base;
    out_ready[k] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[k] = 1'b1;
      op[k] = 3'b000;
      a[k]  = av[i];
      b[k]  = bv[i];
      @(negedge clk);
      n_checks++;
      if (in_ready[k] !== 1'b1) begin
        n_errors++;
        $display("FAIL stream[%0d] in_ready op%0d: got %b expected 1", k, i, in_ready[k]);
      end
      if (in_valid[k] && in_ready[k]) begin
        exp_q.push_back(model(3'b000, av[i], bv[i]));
        acc_q.push_back(cyc);
      end
      tick();
    end
    in_valid[k] = 1'b0;
    for (int c = 0; c < 20 && got_n[k] < base + 4; c++) tick();
    n_checks++;
    if (got_n[k] !== base + 4) begin
      n_errors++;
      $display("FAIL stream[%0d] result count: got %0d expected 4", k, got_n[k] - base);
    end
    while (rd < got_n[k] && exp_q.size() > 0 && rd - base < 4) begin
      ex = exp_q.pop_front();
      ac = acc_q.pop_front();
      n_checks++;
      if ({got_e[k][rd % 64], got_y[k][rd % 64]} !== ex) begin
        n_errors++;
        $display("FAIL stream[%0d] model #%0d: got %h expected %h", k, rd - base,
                 {got_e[k][rd % 64], got_y[k][rd % 64]}, ex);
      end
      n_checks++;
      if (got_y[k][rd % 64] !== want[rd - base]) begin
        n_errors++;
        $display("FAIL stream[%0d] value #%0d: got %h expected %h", k, rd - base,
                 got_y[k][rd % 64], want[rd - base]);
      end
      n_checks++;
      if (got_cyc[k][rd % 64] - ac !== s) begin
        n_errors++;
        $display("FAIL stream[%0d] latency #%0d: got %0d expected %0d", k, rd - base,
                 got_cyc[k][rd % 64] - ac, s);
      end
      rd++;
    end
  endtask

  task automatic test_ops;
    logic [2:0]   ov [7];
    logic [W-1:0] av [7];
    logic [W-1:0] bv [7];
    logic [W-1:0] wy [7];
    logic         we [7];
    logic [W:0]   ex;
    int base, rd;
    ov = '{3'd2, 3'd1, 3'd3, 3'd7, 3'd4, 3'd6, 3'd5};
    av = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h13572468,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    bv = '{32'h0F0F0F0F, 32'h00FF00FF, 32'h55555555, 32'hFFFFFFFF,
           32'h00000000, 32'h0F0F0F0F, 32'hFFFF0000};
`ifdef LOGIC_ZBB_EN
    wy = '{32'h0E0D0E0F, 32'h12FF56FF, 32'hDEADBEEF, 32'h00000000,
           32'h00000000, 32'hF0F0F0F0, 32'h0000FFFF};
    we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    wy = '{32'h0E0D0E0F, 32'h12FF56FF, 32'hDEADBEEF, 32'h00000000,
           32'h00000000, 32'h00000000, 32'h00000000};
    we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    exp_q.delete();
    base = got_n[0];
    rd   = base;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid[0] = 1'b1;
      op[0] = ov[i];
      a[0]  = av[i];
      b[0]  = bv[i];
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) exp_q.push_back(model(ov[i], av[i], bv[i]));
      tick();
    end
    in_valid[0] = 1'b0;
    for (int c = 0; c < 20 && got_n[0] < base + 7; c++) tick();
    n_checks++;
    if (got_n[0] !== base + 7) begin
      n_errors++;
      $display("FAIL ops result count: got %0d expected 7", got_n[0] - base);
    end
    while (rd < got_n[0] && exp_q.size() > 0 && rd - base < 7) begin
      ex = exp_q.pop_front();
      n_checks++;
      if ({got_e[0][rd % 64], got_y[0][rd % 64]} !== ex) begin
        n_errors++;
        $display("FAIL ops model #%0d: got %h expected %h", rd - base,
                 {got_e[0][rd % 64], got_y[0][rd % 64]}, ex);
      end
      n_checks++;
      if (got_y[0][rd % 64] !== wy[rd - base] || got_e[0][rd % 64] !== we[rd - base]) begin
        n_errors++;
        $display("FAIL ops op=%b Y/err: got %h/%b expected %h/%b", ov[rd - base],
                 got_y[0][rd % 64], got_e[0][rd % 64], wy[rd - base], we[rd - base]);
      end
      rd++;
    end
  endtask

  task automatic test_backpressure(input int k);
    logic [2:0]   ov [4];
    logic [W-1:0] av [4];
    logic [W-1:0] bv [4];
    logic [W-1:0] y_hold;
    logic         e_hold, have_hold, acc;
    logic [W:0]   ex;
    int s, p, base, rd;
    ov = '{3'b000, 3'b001, 3'b010, 3'b111};
    av = '{32'h12345678, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hFFFFFFFF};
    bv = '{32'h00FF00FF, 32'h0F0F0F0F, 32'h3C3C3C3C, 32'h00000001};
    s = stages_of(k);
    p = 0;
    have_hold = 1'b0;
    y_hold = '0;
    e_hold = 1'b0;
    exp_q.delete();
    base = got_n[k];
    rd   = base;
    for (int c = 0; c < 60 && (p < 4 || got_n[k] < base + 4); c++) begin
      out_ready[k] = (c >= HOLD);
      if (p < 4) begin
        in_valid[k] = 1'b1;
        op[k] = ov[p];
        a[k]  = av[p];
        b[k]  = bv[p];
      end else begin
        in_valid[k] = 1'b0;
      end
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (in_ready[k] !== 1'b1) begin
          n_errors++;
          $display("FAIL bp[%0d] initial in_ready: got %b expected 1", k, in_ready[k]);
        end
      end
      if (c == HOLD - 1) begin
        n_checks++;
        if (in_ready[k] !== 1'b0) begin
          n_errors++;
          $display("FAIL bp[%0d] in_ready when full: got %b expected 0", k, in_ready[k]);
        end
        n_checks++;
        if (p !== s) begin
          n_errors++;
          $display("FAIL bp[%0d] accepted while stalled: got %0d expected %0d", k, p, s);
        end
        n_checks++;
        if (out_valid[k] !== 1'b1) begin
          n_errors++;
          $display("FAIL bp[%0d] out_valid while stalled: got %b expected 1", k, out_valid[k]);
        end
      end
      if (c < HOLD && out_valid[k] === 1'b1) begin
        if (have_hold) begin
          n_checks++;
          if (y[k] !== y_hold || err[k] !== e_hold) begin
            n_errors++;
            $display("FAIL bp[%0d] stall hold c=%0d: got %h/%b expected %h/%b", k, c,
                     y[k], err[k], y_hold, e_hold);
          end
        end else begin
          y_hold = y[k];
          e_hold = err[k];
          have_hold = 1'b1;
        end
      end
      acc = in_valid[k] & in_ready[k];
      if (acc) exp_q.push_back(model(ov[p], av[p], bv[p]));
      tick();
      if (acc) p++;
    end
    in_valid[k] = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (got_n[k] !== base + 4) begin
      n_errors++;
      $display("FAIL bp[%0d] result count: got %0d expected 4", k, got_n[k] - base);
    end
    while (rd < got_n[k] && exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_checks++;
      if ({got_e[k][rd % 64], got_y[k][rd % 64]} !== ex) begin
        n_errors++;
        $display("FAIL bp[%0d] order #%0d: got %h expected %h", k, rd - base,
                 {got_e[k][rd % 64], got_y[k][rd % 64]}, ex);
      end
      rd++;
    end
  endtask

  task automatic test_flush;
    int base;
    base = got_n[0];
    out_ready[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[0] = 1'b1;
      op[0] = 3'b001;
      a[0]  = 32'h00000100 + i;
      b[0]  = 32'h00000010;
      tick();
    end
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    op[0] = 3'b011;
    a[0]  = 32'hCAFEF00D;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL flush in_ready: got %b expected 0", in_ready[0]);
    end
    n_checks++;
    if (busy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL flush busy before: got %b expected 1", busy[0]);
    end
    tick();
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL flush busy/out_valid after: got %b/%b expected 0/0", busy[0], out_valid[0]);
    end
    out_ready[0] = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (got_n[0] !== base) begin
      n_errors++;
      $display("FAIL flush leaked results: got %0d expected 0", got_n[0] - base);
    end
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL flush in_ready after: got %b expected 1", in_ready[0]);
    end
  endtask

  task automatic test_async_reset;
    int base;
    base = got_n[0];
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    op[0] = 3'b000;
    a[0]  = 32'h0000FFFF;
    b[0]  = 32'h00FF00FF;
    tick();
    in_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL areset pre out_valid: got %b expected 1", out_valid[0]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || y[0] !== '0) begin
      n_errors++;
      $display("FAIL areset immediate: got out_valid=%b busy=%b Y=%h expected 0/0/0",
               out_valid[0], busy[0], y[0]);
    end
    tick();
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (got_n[0] !== base) begin
      n_errors++;
      $display("FAIL areset leaked results: got %0d expected 0", got_n[0] - base);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      flush[k]     = 1'b0;
      in_valid[k]  = 1'b0;
      op[k]        = 3'b000;
      a[k]         = '0;
      b[k]         = '0;
      out_ready[k] = 1'b1;
    end
    test_reset();
    for (int k = 0; k < NI; k++) test_stream(k);
    test_ops();
    for (int k = 0; k < NI; k++) test_backpressure(k);
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
